// File: rtl/priority_encoder8to3_if.sv
// ---------------------------------------------------------------------------
// priority_encoder8to3_if
//   Bundles the event/handshake signals of the sequential 8-to-3 priority
//   encoder.
//
//   Handshake: a code in Y is transferred at a rising edge where
//   valid && ready. While valid && !ready, Y and valid are held unchanged.
//   valid only drops after a transfer (or on reset).
//
//   Signals:
//     D     [7:0]  event pulses, one cycle high = one event on that line
//     ready        consumer accepts Y this cycle
//     valid        Y holds a valid code
//     Y     [2:0]  encoded line index
//     pend  [7:0]  captured events not yet loaded into Y
//     ovf          sticky overflow, an event was lost
//
//   Modports:
//     master  event source / consumer side (drives D and ready)
//     slave   encoder side
// ---------------------------------------------------------------------------
interface priority_encoder8to3_if;
    logic [7:0] D;
    logic       ready;
    logic       valid;
    logic [2:0] Y;
    logic [7:0] pend;
    logic       ovf;

    modport master (
        output D,
        output ready,
        input  valid,
        input  Y,
        input  pend,
        input  ovf
    );

    modport slave (
        input  D,
        input  ready,
        output valid,
        output Y,
        output pend,
        output ovf
    );
endinterface

// File: rtl/priority_encoder8to3.sv
// ---------------------------------------------------------------------------
// priority_encoder8to3
//   Sequential 8-to-3 priority encoder with event queuing. Every event pulse
//   on D is remembered in a pending register; pending lines are emitted one
//   at a time as a 3-bit index on a valid/ready output. Priority is decided
//   at load time, so a later high-priority event overtakes older ones.
//
//   Parameters:
//     PRIO_HIGH  1 = highest index wins, 0 = lowest index wins
//
//   Ports:
//     clk   clock, all state updates on rising edge
//     rst   synchronous, active-high reset
//     bus   slave modport of priority_encoder8to3_if (D, ready, valid, Y,
//           pend, ovf)
//
//   All outputs come straight from flops.
// ---------------------------------------------------------------------------
module priority_encoder8to3 #(
    parameter bit PRIO_HIGH = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    priority_encoder8to3_if.slave  bus
);

    logic [7:0] pend_q, pend_d;
    logic       valid_q, valid_d;
    logic [2:0] y_q, y_d;
    logic       ovf_q, ovf_d;

    logic [7:0] next_v;
    logic [2:0] win_idx;
    logic       slot_free;

    // Winner selection over pending-or-arriving events.
    always_comb begin
        next_v  = pend_q | bus.D;
        win_idx = 3'd0;
        if (PRIO_HIGH) begin
            // Last set bit scanning upward wins -> highest index.
            for (int i = 0; i < 8; i++) begin
                if (next_v[i]) win_idx = 3'(i);
            end
        end else begin
            // Last set bit scanning downward wins -> lowest index.
            for (int i = 7; i >= 0; i--) begin
                if (next_v[i]) win_idx = 3'(i);
            end
        end
    end

    assign slot_free = !valid_q || bus.ready;

    always_comb begin
        pend_d  = pend_q;
        valid_d = valid_q;
        y_d     = y_q;
        // A line already pending that fires again loses an event. A line
        // whose code sits in Y has P[i]=0, so it is simply queued again.
        ovf_d   = ovf_q | (|(bus.D & pend_q));

        if (slot_free) begin
            if (next_v != 8'h00) begin
                y_d     = win_idx;
                valid_d = 1'b1;
                // Clearing the winner also absorbs a same-cycle event on
                // that line: one code is emitted for both.
                pend_d  = next_v & ~(8'h01 << win_idx);
            end else begin
                valid_d = 1'b0;
                pend_d  = 8'h00;
            end
        end else begin
            pend_d = next_v;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= 8'h00;
            valid_q <= 1'b0;
            y_q     <= 3'd0;
            ovf_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            valid_q <= valid_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.valid = valid_q;
    assign bus.Y     = y_q;
    assign bus.pend  = pend_q;
    assign bus.ovf   = ovf_q;

endmodule
